// File: rtl/qspi_psram_ctrl.sv
// ============================================================================
//  Module      : qspi_psram_ctrl
//  Description : QSPI PSRAM controller. Issues the quad-enable unlock (0x35)
//                after reset, then serves single 32-bit little-endian read
//                (0xEB) and write (0x38) transactions with SCK = clk_i/2.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module qspi_psram_ctrl #(
    parameter int unsigned CS_GAP = 2
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [23:0] adr_i,
    input  logic [31:0] wdat_i,
    output logic [31:0] rdat_o,
    output logic        ack_o,
    output logic        ready_o,
    output logic        sck_o,
    output logic        cs_on,
    output logic [3:0]  io_o,
    output logic [3:0]  io_oe_o,
    input  logic [3:0]  io_i
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_GAP   = 3'd1,
        S_IDLE  = 3'd2,
        S_CMD   = 3'd3,
        S_ADR   = 3'd4,
        S_DUMMY = 3'd5,
        S_DATA  = 3'd6,
        S_TAIL  = 3'd7
    } state_t;

    localparam logic [7:0]  c_CMD_UNLOCK = 8'h35;
    localparam logic [7:0]  c_CMD_READ   = 8'hEB;
    localparam logic [7:0]  c_CMD_WRITE  = 8'h38;
    // GAP is counted in clk_i cycles; the TAIL pulse already covers one SCK period.
    localparam int unsigned c_GAP_CLKS   = 2 * (CS_GAP - 1);
    localparam logic [4:0]  c_GAP_LAST   = 5'((c_GAP_CLKS == 0) ? 0 : (c_GAP_CLKS - 1));

    state_t      r_state, w_state;
    logic [4:0]  r_cnt, w_cnt;
    logic        r_init_pend, w_init_pend;
    logic        r_sck, w_sck;
    logic        r_cs_n, w_cs_n;
    logic [3:0]  r_io, w_io;
    logic [3:0]  r_oe, w_oe;
    logic        r_ack, w_ack;
    logic        r_ready, w_ready;
    logic [31:0] r_rdat, w_rdat;
    logic [31:0] r_shift, w_shift;
    logic        r_we;
    logic [23:0] r_adr;
    logic [31:0] r_wdat;

    logic        w_accept;
    logic        w_we;
    logic [23:0] w_adr;
    logic [31:0] w_wdat;
    logic [4:0]  w_pos;

    // A request is only taken in IDLE; transaction fields come straight from
    // the inputs in the accepting cycle so CMD bit 7 can be driven at once.
    assign w_accept = (r_state == S_IDLE) && req_i;
    assign w_we     = (r_state == S_IDLE) ? we_i   : r_we;
    assign w_adr    = (r_state == S_IDLE) ? adr_i  : r_adr;
    assign w_wdat   = (r_state == S_IDLE) ? wdat_i : r_wdat;
    // Nibble position of DATA period k: byte k/2, high nibble on even k.
    assign w_pos    = {r_cnt[2:1], ~r_cnt[0], 2'b00};

    // Pin values for one SCK period: {cs_n, oe[3:0], io[3:0]}.
    function automatic logic [8:0] period_drive(
        input state_t      st,
        input logic [2:0]  k,
        input logic        we,
        input logic [23:0] adr,
        input logic [31:0] wdat
    );
        logic [7:0] cmd;
        logic [3:0] nib;
        logic [4:0] pos;
        logic [8:0] d;
        d   = {1'b1, 4'h0, 4'h0};
        nib = 4'h0;
        cmd = we ? c_CMD_WRITE : c_CMD_READ;
        pos = {k[2:1], ~k[0], 2'b00};
        case (st)
            S_INIT:  d = {1'b0, 4'b0001, 3'b000, c_CMD_UNLOCK[3'd7 - k]};
            S_CMD:   d = {1'b0, 4'b0001, 3'b000, cmd[3'd7 - k]};
            S_ADR: begin
                case (k)
                    3'd0:    nib = adr[23:20];
                    3'd1:    nib = adr[19:16];
                    3'd2:    nib = adr[15:12];
                    3'd3:    nib = adr[11:8];
                    3'd4:    nib = adr[7:4];
                    default: nib = adr[3:0];
                endcase
                d = {1'b0, 4'hF, nib};
            end
            S_DUMMY: d = {1'b0, 4'h0, 4'h0};
            S_DATA:  d = we ? {1'b0, 4'hF, wdat[pos +: 4]} : {1'b0, 4'h0, 4'h0};
            default: d = {1'b1, 4'h0, 4'h0};
        endcase
        return d;
    endfunction

    // Next-state and next-output logic: each SCK period is a low cycle
    // (pins updated) followed by a high cycle (io_i sampled on entry).
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_init_pend = r_init_pend;
        w_sck       = r_sck;
        w_cs_n      = r_cs_n;
        w_io        = r_io;
        w_oe        = r_oe;
        w_ack       = 1'b0;
        w_ready     = r_ready;
        w_rdat      = r_rdat;
        w_shift     = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state = S_CMD;
                    w_cnt   = 5'd0;
                    w_ready = 1'b0;
                    w_sck   = 1'b0;
                    {w_cs_n, w_oe, w_io} = period_drive(S_CMD, 3'd0, w_we, w_adr, w_wdat);
                end
            end
            S_GAP: begin
                w_sck = 1'b0;
                if (r_cnt >= c_GAP_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = 5'd0;
                    w_ready = 1'b1;
                end else begin
                    w_cnt = r_cnt + 5'd1;
                end
            end
            default: begin
                if (r_init_pend) begin
                    // First cycle after reset: open the unlock command.
                    w_init_pend = 1'b0;
                    w_state     = S_INIT;
                    w_cnt       = 5'd0;
                    w_sck       = 1'b0;
                    {w_cs_n, w_oe, w_io} = period_drive(S_INIT, 3'd0, w_we, w_adr, w_wdat);
                end else if (!r_sck) begin
                    // Rising SCK: capture what the device drove in the low cycle.
                    w_sck = 1'b1;
                    if (r_state == S_DATA) begin
                        if (!r_we) begin
                            w_shift[w_pos +: 4] = io_i;
                        end
                        if (r_cnt == 5'd7) begin
                            w_ack = 1'b1;
                            if (!r_we) begin
                                w_rdat = w_shift;
                            end
                        end
                    end
                end else begin
                    // Falling SCK: advance to the next period and drive its pins.
                    w_sck = 1'b0;
                    w_cnt = r_cnt + 5'd1;
                    case (r_state)
                        S_INIT:  if (r_cnt == 5'd7) begin w_state = S_TAIL; w_cnt = 5'd0; end
                        S_CMD:   if (r_cnt == 5'd7) begin w_state = S_ADR;  w_cnt = 5'd0; end
                        S_ADR: begin
                            if (r_cnt == 5'd5) begin
                                w_state = r_we ? S_DATA : S_DUMMY;
                                w_cnt   = 5'd0;
                            end
                        end
                        S_DUMMY: if (r_cnt == 5'd5) begin w_state = S_DATA; w_cnt = 5'd0; end
                        S_DATA:  if (r_cnt == 5'd7) begin w_state = S_TAIL; w_cnt = 5'd0; end
                        S_TAIL:  begin w_state = S_GAP; w_cnt = 5'd0; end
                        default: w_cnt = r_cnt;
                    endcase
                    {w_cs_n, w_oe, w_io} = period_drive(w_state, w_cnt[2:0], r_we, r_adr, r_wdat);
                end
            end
        endcase
    end

    // FSM state register; reset restarts the unlock sequence.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_INIT;
            r_cnt       <= 5'd0;
            r_init_pend <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_init_pend <= w_init_pend;
        end
    end

    // Registered pins, handshake and read data.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_io    <= 4'h0;
            r_oe    <= 4'h0;
            r_ack   <= 1'b0;
            r_ready <= 1'b0;
            r_rdat  <= 32'h0;
            r_shift <= 32'h0;
        end else begin
            r_sck   <= w_sck;
            r_cs_n  <= w_cs_n;
            r_io    <= w_io;
            r_oe    <= w_oe;
            r_ack   <= w_ack;
            r_ready <= w_ready;
            r_rdat  <= w_rdat;
            r_shift <= w_shift;
        end
    end

    // Latch the request fields when a transaction is accepted.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_we   <= 1'b0;
            r_adr  <= 24'h0;
            r_wdat <= 32'h0;
        end else if (w_accept) begin
            r_we   <= we_i;
            r_adr  <= adr_i;
            r_wdat <= wdat_i;
        end
    end

    assign sck_o   = r_sck;
    assign cs_on   = r_cs_n;
    assign io_o    = r_io;
    assign io_oe_o = r_oe;
    assign ack_o   = r_ack;
    assign ready_o = r_ready;
    assign rdat_o  = r_rdat;

endmodule

`default_nettype wire

// File: tb/tb_qspi_psram_ctrl.sv
// ============================================================================
//  Module      : tb_qspi_psram_ctrl
//  Description : Self-checking bench for qspi_psram_ctrl with a behavioural
//                QSPI PSRAM model and a table of directed transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qspi_psram_ctrl;

    localparam int CS_GAP = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [23:0] adr    = 24'h0;
    logic [31:0] wdat   = 32'h0;
    logic [3:0]  io_i   = 4'h0;
    logic [31:0] rdat_o;
    logic        ack_o;
    logic        ready_o;
    logic        sck_o;
    logic        cs_on;
    logic [3:0]  io_o;
    logic [3:0]  io_oe_o;

    always #5 clk = ~clk;

    qspi_psram_ctrl #(.CS_GAP(CS_GAP)) dut (
        .clk_i   (clk),
        .rst_in  (rst_n),
        .req_i   (req),
        .we_i    (we),
        .adr_i   (adr),
        .wdat_i  (wdat),
        .rdat_o  (rdat_o),
        .ack_o   (ack_o),
        .ready_o (ready_o),
        .sck_o   (sck_o),
        .cs_on   (cs_on),
        .io_o    (io_o),
        .io_oe_o (io_oe_o),
        .io_i    (io_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- PSRAM model (sampled on the falling clk edge) ----------
    logic [7:0]  mem [0:4095];
    logic        sck_prev   = 1'b0;
    bit          in_txn     = 1'b0;
    int          edges      = 0;
    logic [7:0]  cmd        = 8'h0;
    logic [23:0] madr       = 24'h0;
    bit          oe_bad     = 1'b0;
    logic [7:0]  last_cmd   = 8'h0;
    int          last_edges = 0;
    int          unlock_cnt = 0;
    int          tail_cnt   = 0;
    int          ack_cnt    = 0;
    int          ack_edges  = 0;
    int          glitch_cnt = 0;
    logic [3:0]  prev_io    = 4'h0;
    logic [3:0]  prev_oe    = 4'h0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    end

    always @(negedge clk) begin
        logic        rise;
        logic        fall;
        int          j;
        logic [23:0] b;
        rise = sck_o && !sck_prev;
        fall = !sck_o && sck_prev;
        sck_prev = sck_o;
        if (sck_o && (io_o !== prev_io || io_oe_o !== prev_oe)) glitch_cnt++;
        prev_io = io_o;
        prev_oe = io_oe_o;
        if (cs_on) begin
            if (in_txn) begin
                last_cmd   = cmd;
                last_edges = edges;
                if (cmd == 8'h35 && edges == 8) unlock_cnt++;
                in_txn = 1'b0;
            end
            if (rise) tail_cnt++;
            io_i = 4'h0;
        end else begin
            if (!in_txn) begin
                in_txn = 1'b1;
                edges  = 0;
                cmd    = 8'h0;
                madr   = 24'h0;
                oe_bad = 1'b0;
            end
            if (rise) begin
                if (edges < 8) begin
                    cmd = {cmd[6:0], io_o[0]};
                    if (io_oe_o !== 4'b0001) oe_bad = 1'b1;
                end else if (edges < 14) begin
                    madr = {madr[19:0], io_o};
                    if (io_oe_o !== 4'hF) oe_bad = 1'b1;
                end else if (cmd == 8'h38) begin
                    if (io_oe_o !== 4'hF) oe_bad = 1'b1;
                    if (edges < 22) begin
                        j = edges - 14;
                        b = madr + 24'(j / 2);
                        if (j % 2 == 0) mem[b[11:0]][7:4] = io_o;
                        else            mem[b[11:0]][3:0] = io_o;
                    end
                end else begin
                    if (io_oe_o !== 4'h0) oe_bad = 1'b1;
                end
                edges++;
            end
            if (fall && cmd == 8'hEB && edges >= 20 && edges < 28) begin
                j = edges - 20;
                b = madr + 24'(j / 2);
                io_i = (j % 2 == 0) ? mem[b[11:0]][7:4] : mem[b[11:0]][3:0];
            end
        end
        if (ack_o) begin
            ack_cnt++;
            ack_edges = edges;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ready(input string name, input int bound);
        for (int i = 0; i < bound && !ready_o; i++) @(negedge clk);
        check(name, {31'h0, ready_o}, 32'h1);
    endtask

    task automatic run_txn(input logic t_we, input logic [23:0] t_adr, input logic [31:0] t_wdat,
                           output logic got_ack, output logic [31:0] got_rdat);
        got_ack  = 1'b0;
        got_rdat = 32'h0;
        @(negedge clk);
        we = t_we; adr = t_adr; wdat = t_wdat; req = 1'b1;
        for (int i = 0; i < 200 && !got_ack; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got_ack  = 1'b1;
                got_rdat = rdat_o;
            end
        end
        req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [23:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp_rdat;
        int          exp_len;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        logic        got_ack;
        logic [31:0] got_rdat;
        logic [11:0] a;
        int          acks0, tails0, unl0, seen, cs_high;
        bit          found;

        vecs[0] = '{we: 1'b1, adr: 24'h000100, wdat: 32'hDEADBEEF, exp_rdat: 32'h0,        exp_len: 22};
        vecs[1] = '{we: 1'b0, adr: 24'h000100, wdat: 32'h0,        exp_rdat: 32'hDEADBEEF, exp_len: 28};
        vecs[2] = '{we: 1'b1, adr: 24'h000003, wdat: 32'h11223344, exp_rdat: 32'h0,        exp_len: 22};
        vecs[3] = '{we: 1'b0, adr: 24'h000003, wdat: 32'h0,        exp_rdat: 32'h11223344, exp_len: 28};
        vecs[4] = '{we: 1'b0, adr: 24'h000101, wdat: 32'h0,        exp_rdat: 32'h00DEADBE, exp_len: 28};
        vecs[5] = '{we: 1'b1, adr: 24'h000201, wdat: 32'h0A0B0C0D, exp_rdat: 32'h0,        exp_len: 22};
        vecs[6] = '{we: 1'b0, adr: 24'h000200, wdat: 32'h0,        exp_rdat: 32'h0B0C0D00, exp_len: 28};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs",    {31'h0, cs_on},   32'h1);
        check("rst_sck",   {31'h0, sck_o},   32'h0);
        check("rst_oe",    {28'h0, io_oe_o}, 32'h0);
        check("rst_io",    {28'h0, io_o},    32'h0);
        check("rst_ack",   {31'h0, ack_o},   32'h0);
        check("rst_ready", {31'h0, ready_o}, 32'h0);
        check("rst_rdat",  rdat_o,           32'h0);

        // Unlock sequence after release
        rst_n = 1'b1;
        wait_ready("unlock_ready", 100);
        #1;
        check("unlock_cmd",   {24'h0, last_cmd}, 32'h35);
        check("unlock_edges", 32'(last_edges),   32'd8);
        check("unlock_oe",    {31'h0, oe_bad},   32'h0);
        check("unlock_tail",  32'(tail_cnt),     32'd1);
        check("unlock_cnt",   32'(unlock_cnt),   32'd1);

        // Table-driven transactions
        for (int k = 0; k < 7; k++) begin
            acks0  = ack_cnt;
            tails0 = tail_cnt;
            run_txn(vecs[k].we, vecs[k].adr, vecs[k].wdat, got_ack, got_rdat);
            wait_ready($sformatf("v%0d_ready", k), 100);
            #1;
            check($sformatf("v%0d_ack", k),    {31'h0, got_ack},        32'h1);
            check($sformatf("v%0d_len", k),    32'(last_edges),         32'(vecs[k].exp_len));
            check($sformatf("v%0d_ack_at", k), 32'(ack_edges),          32'(vecs[k].exp_len));
            check($sformatf("v%0d_oe", k),     {31'h0, oe_bad},         32'h0);
            check($sformatf("v%0d_nack", k),   32'(ack_cnt - acks0),    32'd1);
            check($sformatf("v%0d_tail", k),   32'(tail_cnt - tails0),  32'd1);
            a = vecs[k].adr[11:0];
            if (vecs[k].we)
                check($sformatf("v%0d_bytes", k), {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]}, vecs[k].wdat);
            else
                check($sformatf("v%0d_rdat", k), got_rdat, vecs[k].exp_rdat);
        end
        check("bytes_100", {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]}, 32'hEFBEADDE);
        check("bytes_003", {mem[12'h003], mem[12'h004], mem[12'h005], mem[12'h006]}, 32'h44332211);

        // Back-to-back requests with req held high
        acks0   = ack_cnt;
        seen    = 0;
        cs_high = 0;
        @(negedge clk);
        we = 1'b1; adr = 24'h000300; wdat = 32'h55667788; req = 1'b1;
        for (int i = 0; i < 400 && seen < 2; i++) begin
            @(negedge clk);
            if (ack_o) begin
                seen++;
                if (seen == 1) begin
                    adr  = 24'h000304;
                    wdat = 32'h99AABBCC;
                end
            end else if (seen == 1 && cs_on) begin
                cs_high++;
            end
        end
        @(negedge clk);
        req = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        check("b2b_acks",    32'(seen),            32'd2);
        check("b2b_gap",     {31'h0, (cs_high >= 2 * CS_GAP)}, 32'h1);
        check("b2b_nodup",   32'(ack_cnt - acks0), 32'd2);
        check("b2b_bytes0",  {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]}, 32'h88776655);
        check("b2b_bytes1",  {mem[12'h304], mem[12'h305], mem[12'h306], mem[12'h307]}, 32'hCCBBAA99);
        check("b2b_ready",   {31'h0, ready_o},     32'h1);

        // Reset during the DATA phase of a read
        acks0 = ack_cnt;
        unl0  = unlock_cnt;
        found = 1'b0;
        @(negedge clk);
        we = 1'b0; adr = 24'h000100; req = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!cs_on) found = 1'b1;
        end
        check("mid_start", {31'h0, found}, 32'h1);
        repeat (44) @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("mid_cs",  {31'h0, cs_on},   32'h1);
        check("mid_sck", {31'h0, sck_o},   32'h0);
        check("mid_oe",  {28'h0, io_oe_o}, 32'h0);
        check("mid_ack", {31'h0, ack_o},   32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("mid_ready", 100);
        #1;
        check("mid_unlock", 32'(unlock_cnt - unl0), 32'd1);
        check("mid_noack",  32'(ack_cnt - acks0),   32'd0);
        run_txn(1'b0, 24'h000100, 32'h0, got_ack, got_rdat);
        check("post_ack",  {31'h0, got_ack}, 32'h1);
        check("post_rdat", got_rdat,         32'hDEADBEEF);
        wait_ready("post_ready", 100);

        check("io_stable_high", 32'(glitch_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qspi_psram_ctrl.md
QSPI_PSRAM_CTRL -- requirements
Module: qspi_psram_ctrl

Interface
REQ-001 SHALL have parameter CS_GAP, default 2, meaning the minimum number of SCK periods cs_on stays high between transactions (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  system clock; SCK is derived from it.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_i  input  1  transaction request, held by the requester until ack_o.
REQ-005 SHALL have port we_i  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-006 SHALL have port adr_i  input  24  byte address of the first byte; sampled at acceptance.
REQ-007 SHALL have port wdat_i  input  32  write word, little-endian; sampled at acceptance.
REQ-008 SHALL have port rdat_o  output  32  read word, little-endian; valid while ack_o=1.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ready_o  output  1  high when the unlock is done and the FSM is in IDLE.
REQ-011 SHALL have port sck_o  output  1  serial clock, idle low.
REQ-012 SHALL have port cs_on  output  1  chip select, active-low.
REQ-013 SHALL have port io_o  output  4  QSPI data out; bit n maps to ioN.
REQ-014 SHALL have port io_oe_o  output  4  per-bit output enable.
REQ-015 SHALL have port io_i  input  4  QSPI data in.

Function
REQ-016 SHALL generate SCK at clk_i/2, each bit period being one clk_i with sck_o=0 followed by one clk_i with sck_o=1; io_o/io_oe_o change only in the sck_o=0 cycle.
REQ-017 SHALL sample io_i in the clk_i cycle that drives sck_o 0->1, capturing the value present just before the rising edge.
REQ-018 SHALL implement FSM states INIT, GAP, IDLE, CMD, ADR, DUMMY, DATA, TAIL.
REQ-019 SHALL leave reset in INIT, pull cs_on low, and shift 0x35 MSB-first on io0 (io_oe_o=4'b0001) over 8 SCK periods, then go to TAIL.
REQ-020 SHALL, in TAIL, raise cs_on and emit exactly one further SCK pulse with io_oe_o=0, because the device only returns to command state on an SCK edge while deselected; TAIL then goes to GAP.
REQ-021 SHALL hold cs_on high in GAP for CS_GAP SCK periods (this count includes the TAIL pulse), then go to IDLE.
REQ-022 SHALL accept a request in IDLE when req_i=1, capturing we_i, adr_i and wdat_i, and drive cs_on low in the next cycle; req_i in any other state is ignored.
REQ-023 SHALL, in CMD, shift 0xEB (read) or 0x38 (write) MSB-first on io0 only, over 8 periods.
REQ-024 SHALL, in ADR, drive adr[23:0] on io[3:0] as 6 nibbles, most significant first, with io_oe_o=4'hF.
REQ-025 SHALL, for reads, spend 6 DUMMY periods with io_oe_o=0, then 8 DATA periods with io_oe_o=0 capturing nibbles.
REQ-026 SHALL, for writes, go ADR->DATA directly and drive 8 nibbles with io_oe_o=4'hF.
REQ-027 SHALL order DATA bytes as byte0 (bits 7:0) first through byte3 last, high nibble first within each byte; the device addresses them at adr, adr+1, adr+2, adr+3.
REQ-028 SHALL pass adr_i unchanged: no alignment check, and address increment/wrap past 0xFFFFFF is the device's concern.
REQ-029 SHALL, after the last DATA rising edge, assert ack_o for exactly one cycle with rdat_o valid (reads), then enter TAIL.
REQ-030 SHALL hold rdat_o stable until the next read's ack_o.
REQ-031 SHALL use a transaction length of 28 SCK periods for reads and 22 for writes, excluding TAIL and GAP.
REQ-032 SHALL not start a new transaction until GAP has completed, so a request held one cycle past ack_o is not re-accepted.

Reset
REQ-033 SHALL, on rst_in=0 and immediately (asynchronously), force cs_on=1, sck_o=0, io_oe_o=0, io_o=0, ack_o=0, ready_o=0, rdat_o=0, and FSM state INIT.
REQ-034 SHALL, when reset occurs mid-transaction, abandon that transaction with no ack_o and repeat the unlock sequence after reset release.

Verification
REQ-035 SHALL verify that after reset release, io0 carries 0x35 over 8 rising edges, followed by a TAIL pulse with cs_on=1, then ready_o=1.
REQ-036 SHALL verify that a write of 0xDEADBEEF to 0x000100 yields PSRAM model bytes [0x100..0x103]=EF,BE,AD,DE, with one ack_o after 22 periods.
REQ-037 SHALL verify that a read of 0x000100 after that write gives rdat_o=0xDEADBEEF at ack_o, and that io_oe_o=0 throughout DUMMY and DATA.
REQ-038 SHALL verify that back-to-back requests (req_i held high) produce two acks separated by at least CS_GAP SCK periods with cs_on high, and no duplicate transaction.
REQ-039 SHALL verify that rst_in asserted in the read DATA phase gives cs_on=1 in the same cycle and no ack_o, followed by the unlock, after which a read of 0x000100 returns 0xDEADBEEF.
REQ-040 SHALL verify that an unaligned write of 0x11223344 to 0x000003 yields bytes [3..6]=44,33,22,11.
